// File: rtl/cordic_sincos_if.sv
// Request/result bundle for the CORDIC sine/cosine unit.
// The requester drives start/ang/qrt; the converter returns busy/valid and the results.
interface cordic_sincos_if;
    logic        start;
    logic [15:0] ang;
    logic [1:0]  qrt;
    logic        busy;
    logic        valid;
    logic [15:0] sin_o;
    logic [15:0] cos_o;

    modport master (output start, ang, qrt, input busy, valid, sin_o, cos_o);
    modport slave  (input start, ang, qrt, output busy, valid, sin_o, cos_o);
endinterface

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock within a quadrant,
// followed by a quadrant fold and a registered output update with a one-cycle valid pulse.
module cordic_sincos #(
    parameter int ITER = 14
) (
    input  logic            clk,
    input  logic            rst,
    cordic_sincos_if.slave  bus
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t              state_reg, state_next;
    logic signed [17:0]  x_reg, x_next;
    logic signed [17:0]  y_reg, y_next;
    logic signed [16:0]  z_reg, z_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [1:0]          qrt_reg, qrt_next;
    logic [15:0]         sin_reg, sin_next;
    logic [15:0]         cos_reg, cos_next;
    logic                valid_reg, valid_next;

    logic signed [17:0]  x_shift, y_shift;
    logic signed [16:0]  atan_val;
    logic [15:0]         s_pos, s_neg, c_pos, c_neg;

    // Elementary angles atan(2^-i) in 8.8 degrees.
    function automatic logic signed [16:0] atan_lut(input logic [CW-1:0] i);
        case (int'(i))
            0:       atan_lut = 17'sd11520;
            1:       atan_lut = 17'sd6801;
            2:       atan_lut = 17'sd3593;
            3:       atan_lut = 17'sd1824;
            4:       atan_lut = 17'sd916;
            5:       atan_lut = 17'sd458;
            6:       atan_lut = 17'sd229;
            7:       atan_lut = 17'sd115;
            8:       atan_lut = 17'sd57;
            9:       atan_lut = 17'sd29;
            10:      atan_lut = 17'sd14;
            11:      atan_lut = 17'sd7;
            12:      atan_lut = 17'sd4;
            13:      atan_lut = 17'sd2;
            default: atan_lut = 17'sd0;
        endcase
    endfunction

    assign x_shift  = x_reg >>> cnt_reg;
    assign y_shift  = y_reg >>> cnt_reg;
    assign atan_val = atan_lut(cnt_reg);

    // Quadrant fold operands; negation happens at full width before truncation.
    assign s_pos = y_reg[15:0];
    assign c_pos = x_reg[15:0];
    assign s_neg = 16'(-y_reg);
    assign c_neg = 16'(-x_reg);

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        cnt_next   = cnt_reg;
        qrt_next   = qrt_reg;
        sin_next   = sin_reg;
        cos_next   = cos_reg;
        valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    qrt_next   = bus.qrt;
                    z_next     = (bus.ang > 16'd23040) ? 17'sd23040 : $signed({1'b0, bus.ang});
                    x_next     = 18'sd9949;
                    y_next     = 18'sd0;
                    cnt_next   = '0;
                    state_next = ROTATE;
                end
            end
            ROTATE: begin
                if (!z_reg[16]) begin
                    x_next = x_reg - y_shift;
                    y_next = y_reg + x_shift;
                    z_next = z_reg - atan_val;
                end else begin
                    x_next = x_reg + y_shift;
                    y_next = y_reg - x_shift;
                    z_next = z_reg + atan_val;
                end
                if (cnt_reg == CW'(ITER - 1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                case (qrt_reg)
                    2'b00:   begin sin_next = s_pos; cos_next = c_pos; end
                    2'b01:   begin sin_next = c_pos; cos_next = s_neg; end
                    2'b10:   begin sin_next = s_neg; cos_next = c_neg; end
                    default: begin sin_next = c_neg; cos_next = s_pos; end
                endcase
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            cnt_reg   <= '0;
            qrt_reg   <= '0;
            sin_reg   <= '0;
            cos_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            cnt_reg   <= cnt_next;
            qrt_reg   <= qrt_next;
            sin_reg   <= sin_next;
            cos_reg   <= cos_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.busy  = (state_reg != IDLE);
    assign bus.valid = valid_reg;
    assign bus.sin_o = sin_reg;
    assign bus.cos_o = cos_reg;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: reset, quadrant scenarios, clamp, latency,
// start-while-busy rejection, start-with-valid acceptance and reset abort.
module tb_cordic_sincos;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cordic_sincos_if bus ();

    cordic_sincos #(.ITER(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one start at the next edge, scramble inputs afterwards, and count edges to valid.
    task automatic run_conv(input logic [15:0] a, input logic [1:0] q, output int lat);
        bus.ang   = a;
        bus.qrt   = q;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.ang   = 16'h5A5A;
        bus.qrt   = ~q;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ang   = 16'd0;
        bus.qrt   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++;
        if (bus.sin_o !== 16'd0) begin failures++; $display("FAIL reset_sin: got %0d want 0", $signed(bus.sin_o)); end
        checks++;
        if (bus.cos_o !== 16'd0) begin failures++; $display("FAIL reset_cos: got %0d want 0", $signed(bus.cos_o)); end
        rst = 1'b0;
        $display("txn reset: busy=%b valid=%b sin=%0d cos=%0d", bus.busy, bus.valid,
                 $signed(bus.sin_o), $signed(bus.cos_o));
    endtask

    task automatic test_scenario(input string name, input logic [15:0] a, input logic [1:0] q,
                                 input int es, input int ec);
        int lat;
        int s;
        int c;
        run_conv(a, q, lat);
        s = int'($signed(bus.sin_o));
        c = int'($signed(bus.cos_o));
        $display("txn %s: ang=%0d qrt=%0d latency=%0d sin=%0d cos=%0d", name, a, q, lat, s, c);
        checks++;
        if (lat !== 15) begin failures++; $display("FAIL %s_latency: got %0d want 15", name, lat); end
        checks++;
        if (s - es > 8 || es - s > 8) begin failures++; $display("FAIL %s_sin: got %0d want %0d+/-8", name, s, es); end
        checks++;
        if (c - ec > 8 || ec - c > 8) begin failures++; $display("FAIL %s_cos: got %0d want %0d+/-8", name, c, ec); end
    endtask

    // valid must be a single-cycle pulse and the results must hold afterwards.
    task automatic test_hold();
        logic [15:0] s_prev;
        logic [15:0] c_prev;
        s_prev = bus.sin_o;
        c_prev = bus.cos_o;
        @(posedge clk); #1;
        checks++;
        if (bus.valid !== 1'b0) begin failures++; $display("FAIL hold_pulse: valid got %b want 0", bus.valid); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.sin_o !== s_prev || bus.cos_o !== c_prev) begin
            failures++;
            $display("FAIL hold_outputs: got %h/%h want %h/%h", bus.sin_o, bus.cos_o, s_prev, c_prev);
        end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_idle_busy: got %b want 0", bus.busy); end
        $display("txn hold: sin=%0d cos=%0d busy=%b", $signed(bus.sin_o), $signed(bus.cos_o), bus.busy);
    endtask

    task automatic test_back_to_back();
        int lat;
        int s;
        int c;
        bus.ang   = 16'd0;
        bus.qrt   = 2'd0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                bus.ang   = 16'd11520;
                bus.qrt   = 2'd1;
                bus.start = 1'b1;
            end
            if (k == 3) begin
                bus.start = 1'b0;
                checks++;
                if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_mid: got %b want 1", bus.busy); end
            end
            if (bus.valid) begin
                lat = k;
                break;
            end
        end
        s = int'($signed(bus.sin_o));
        c = int'($signed(bus.cos_o));
        $display("txn b2b_first: latency=%0d sin=%0d cos=%0d", lat, s, c);
        checks++;
        if (lat !== 15) begin failures++; $display("FAIL b2b_first_latency: got %0d want 15", lat); end
        checks++;
        if (s > 8 || s < -8 || c - 16384 > 8 || 16384 - c > 8) begin
            failures++;
            $display("FAIL b2b_first_value: got %0d/%0d want 0/16384+/-8", s, c);
        end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_at_valid: got %b want 0", bus.busy); end
        // Start presented while valid is high must be taken.
        run_conv(16'd7680, 2'd2, lat);
        s = int'($signed(bus.sin_o));
        c = int'($signed(bus.cos_o));
        $display("txn b2b_second: latency=%0d sin=%0d cos=%0d", lat, s, c);
        checks++;
        if (lat !== 15) begin failures++; $display("FAIL b2b_second_latency: got %0d want 15", lat); end
        checks++;
        if (s + 8192 > 8 || -8192 - s > 8 || c + 14189 > 8 || -14189 - c > 8) begin
            failures++;
            $display("FAIL b2b_second_value: got %0d/%0d want -8192/-14189+/-8", s, c);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        bus.ang   = 16'd15360;
        bus.qrt   = 2'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b want 0", bus.valid); end
        checks++;
        if (bus.sin_o !== 16'd0 || bus.cos_o !== 16'd0) begin
            failures++;
            $display("FAIL abort_outputs: got %h/%h want 0/0", bus.sin_o, bus.cos_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus.valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen); end
        $display("txn reset_abort: busy=%b valid_pulses=%0d sin=%0d cos=%0d", bus.busy, seen,
                 $signed(bus.sin_o), $signed(bus.cos_o));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_scenario("deg0",    16'd0,     2'd0,  0,     16384);
        test_hold();
        test_scenario("deg45",   16'd11520, 2'd0,  11585, 11585);
        test_scenario("deg180",  16'd23040, 2'd1,  0,     -16384);
        test_scenario("deg210",  16'd7680,  2'd2, -8192,  -14189);
        test_scenario("clamp90", 16'hFFFF,  2'd0,  16384, 0);
        test_scenario("deg330",  16'd15360, 2'd3, -8192,  14189);
        test_back_to_back();
        test_reset_abort();
        test_scenario("post_rst", 16'd15360, 2'd3, -8192, 14189);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_sincos.md
CORDIC_SINCOS -- requirements
Module: cordic_sincos

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request to convert the present ang/qrt
- ang  in  16  unsigned angle within the quadrant, 8.8 fixed-point degrees (90.0 = 23040)
- qrt  in  2  quadrant index; full angle = qrt*90 deg + ang
- busy  out  1  high while a conversion is in progress
- valid  out  1  one-cycle pulse when sin_o/cos_o are updated
- sin_o  out  16  signed Q2.14 sine (1.0 = 16384)
- cos_o  out  16  signed Q2.14 cosine
REQ-003 Parameter ITER SHALL default to 14 and set the number of micro-rotations.

Function
REQ-004 The FSM SHALL have three states: IDLE, ROTATE, DONE.
REQ-005 In IDLE with start=1 at edge N, the block SHALL do all of the following:
- latch qrt
- clamp ang to 23040 if it is greater, and load z with the result
- load x=9949 (K*2^14) and y=0
- clear the iteration counter
- enter ROTATE
REQ-006 In IDLE with start=0, the block SHALL hold all state.
REQ-007 ROTATE SHALL perform one micro-rotation per clock, for iterations i=0..ITER-1, as follows:
- d = +1 when z >= 0, else d = -1
- x <= x - d*(y>>>i)
- y <= y + d*(x>>>i)
- z <= z - d*atan_i
REQ-008 ROTATE SHALL enter DONE after iteration ITER-1.
REQ-009 The atan table SHALL be in 8.8 degrees: 11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7, 4, 2.
REQ-010 x and y SHALL be 18-bit signed and z SHALL be 17-bit signed; shifts SHALL be arithmetic; no saturation is required internally.
REQ-011 In DONE the block SHALL register the outputs, pulse valid for one cycle, and return to IDLE.
REQ-012 The output mapping from the CORDIC result (s=y, c=x) SHALL be:
- qrt 00: sin_o=s, cos_o=c
- qrt 01: sin_o=c, cos_o=-s
- qrt 10: sin_o=-s, cos_o=-c
- qrt 11: sin_o=-c, cos_o=s
REQ-013 The outputs SHALL be truncated to 16 bits after the mapping; the value range is -16384..16384 plus a few LSB of CORDIC overshoot.
REQ-014 Latency SHALL be fixed: with start sampled at edge N, valid is high and the outputs are updated after edge N+ITER+1 (N+15 at the default).
REQ-015 busy SHALL be high exactly when the state is ROTATE or DONE.
REQ-016 A start that arrives while busy=1 SHALL be ignored (not queued).
REQ-017 A start in the same cycle that valid is high SHALL be accepted, giving a throughput of one conversion per ITER+2 cycles.
REQ-018 sin_o/cos_o SHALL hold their last value until the next DONE.
REQ-019 ang and qrt SHALL only be sampled at acceptance; changes to them during ROTATE SHALL have no effect.
REQ-020 Accuracy SHALL be |error| <= 8 LSB against the ideal round(16384*sin/cos(theta)) for all ang in 0..23040 and all qrt.

Reset
REQ-021 Asserting rst SHALL immediately force the following, independent of clk:
- state=IDLE
- busy=0
- valid=0
- sin_o=0, cos_o=0
- x, y, z and the counter to 0
REQ-022 A reset during ROTATE or DONE SHALL abort the conversion; no valid pulse SHALL follow it.
REQ-023 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-024 Scenario: ang=0, qrt=00, start one cycle -> valid exactly 15 cycles later; sin_o=0 +/-8, cos_o=16384 +/-8.
REQ-025 Scenario: ang=11520 (45 deg), qrt=00 -> sin_o=11585 +/-8, cos_o=11585 +/-8.
REQ-026 Scenario: ang=23040, qrt=01 (180 deg) -> sin_o=0 +/-8, cos_o=-16384 +/-8.
REQ-027 Scenario: ang=7680 (30 deg), qrt=10 (210 deg) -> sin_o=-8192 +/-8, cos_o=-14189 +/-8.
REQ-028 Scenario: ang=0xFFFF, qrt=00 -> clamped to 90 deg; sin_o=16384 +/-8, cos_o=0 +/-8.
REQ-029 Scenario: start pulsed again at cycles 3 and 15 of a conversion, and rst pulsed mid-ROTATE of a third conversion -> the following three checks hold:
- the cycle-3 start is ignored
- the cycle-15 start, concurrent with valid, is accepted
- the rst gives busy=0 and outputs=0 immediately, with no valid pulse
